// File: rtl/fft_input_loader.sv
// Frame loader ahead of the FFT butterfly: collects D_WIDTH complex samples at bit-reversed
// addresses, pulses start, then holds the frame until fft_done. FFT_LOADER_NATURAL_ORDER_EN selects natural order.
module fft_input_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int SAMPLE_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SAMPLE_W-1:0]          in_re,
  input  logic [SAMPLE_W-1:0]          in_im,
  input  logic                         flush,
  input  logic                         fft_done,
  output logic [D_WIDTH*SAMPLE_W-1:0]  out_re,
  output logic [D_WIDTH*SAMPLE_W-1:0]  out_im,
  output logic                         start,
  output logic [LOG_2_WIDTH:0]         fill_count
);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]             state;
  logic [LOG_2_WIDTH-1:0] cnt;
  logic [LOG_2_WIDTH-1:0] wr_addr;
  logic [LOG_2_WIDTH:0]   fill_q;
  logic [SAMPLE_W-1:0]    buf_re [D_WIDTH];
  logic [SAMPLE_W-1:0]    buf_im [D_WIDTH];

  assign in_ready   = (state == S_FILL);
  assign start      = (state == S_LAUNCH);
  assign fill_count = fill_q;

  always_comb begin
`ifdef FFT_LOADER_NATURAL_ORDER_EN
    wr_addr = cnt;
`else
    wr_addr = '0;
    for (int unsigned b = 0; b < LOG_2_WIDTH; b++)
      wr_addr[b] = cnt[LOG_2_WIDTH-1-b];
`endif
  end

  // Flush takes priority over a coincident handshake, so an aborted last sample never launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FILL;
      cnt    <= '0;
      fill_q <= '0;
      for (int unsigned k = 0; k < D_WIDTH; k++) begin
        buf_re[k] <= '0;
        buf_im[k] <= '0;
      end
    end else begin
      case (state)
        S_FILL: begin
          if (flush) begin
            cnt    <= '0;
            fill_q <= '0;
          end else if (in_valid) begin
            buf_re[wr_addr] <= in_re;
            buf_im[wr_addr] <= in_im;
            cnt             <= cnt + 1'b1;
            fill_q          <= fill_q + 1'b1;
            if (&cnt)
              state <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (fft_done || flush) begin
            state  <= S_FILL;
            fill_q <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < D_WIDTH; g++) begin : g_out
    assign out_re[g*SAMPLE_W +: SAMPLE_W] = buf_re[g];
    assign out_im[g*SAMPLE_W +: SAMPLE_W] = buf_im[g];
  end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream neighbour of the butterfly engine.
- Accepts one complex 16-bit sample per cycle over a valid/ready handshake and writes each sample into a D_WIDTH-entry frame buffer at its bit-reversed address.
- When the frame is full, it presents the buffer as parallel Re/Im arrays and issues a one-cycle start pulse to the butterfly.
- It then holds the frame stable until the butterfly reports completion.

Parameters:
- D_WIDTH, 64, samples per frame; must be a power of two.
- LOG_2_WIDTH, 6, log2(D_WIDTH); width of the sample counter and addresses.
- SAMPLE_W, 16, bit width of each Re and Im component.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- in_valid  input  1  a sample is offered on in_re/in_im.
- in_ready  output  1  loader can accept a sample this cycle.
- in_re  input  SAMPLE_W  real part of the offered sample.
- in_im  input  SAMPLE_W  imaginary part of the offered sample.
- flush  input  1  synchronous abort of the current frame.
- fft_done  input  1  one-cycle pulse from the butterfly: frame consumed, buffer may be reused.
- out_re  output  SAMPLE_W x D_WIDTH  parallel real frame, in bit-reversed order.
- out_im  output  SAMPLE_W x D_WIDTH  parallel imaginary frame, in bit-reversed order.
- start  output  1  one-cycle pulse; out_re/out_im are valid and complete.
- fill_count  output  LOG_2_WIDTH+1  number of samples accepted in the current frame (0..D_WIDTH).

Behaviour:
- Reset values (rst high, asynchronous):
  - state=FILL, sample counter=0, fill_count=0, start=0.
  - All buffer entries=0, so out_re/out_im are all zero.
  - in_ready=1 once rst deasserts.
- States: FILL, LAUNCH, WAIT.
- FILL:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready at the clock edge.
  - On accept, buffer[bitrev(cnt)] <= {in_re, in_im}, then cnt <= cnt+1 and fill_count <= fill_count+1.
  - bitrev reverses the LOG_2_WIDTH bits of cnt; for example, with D_WIDTH=64, cnt 1 -> index 32 and cnt 6 -> index 24.
  - An accept at cnt = D_WIDTH-1 moves the block to LAUNCH. The counter wraps to 0 and fill_count reads D_WIDTH.
  - in_valid low means no change.
  - fft_done is ignored in FILL.
- LAUNCH:
  - Lasts exactly one cycle.
  - start=1 and in_ready=0 for that cycle.
  - The buffer is frozen, so out_re/out_im are the complete frame while start is high.
  - Next state is WAIT unconditionally; fft_done in this cycle is ignored.
- WAIT:
  - in_ready=0, start=0, buffer frozen.
  - fft_done=1 moves the block to FILL and sets fill_count to 0.
  - The first new sample can be accepted in the cycle after fft_done.
- flush:
  - In FILL, flush sets cnt=0 and fill_count=0. Buffer contents are not cleared.
  - If a handshake coincides with flush, flush wins: the sample is not written and not counted, and the block does not go to LAUNCH.
  - In WAIT, flush returns the block to FILL, exactly as fft_done does.
  - In LAUNCH, flush is ignored; the start pulse is never truncated or suppressed.
- Latency:
  - The last sample is accepted on edge N.
  - start is high during the cycle following edge N.
  - The buffer is stable from edge N until fft_done/flush is taken in WAIT.
- Width rules:
  - No arithmetic on sample data.
  - Samples are stored bit-exact.
  - fill_count saturates naturally at D_WIDTH because acceptance stops.
- rst mid-frame or in WAIT: immediate return to reset values. A pending start is never issued.
- start is never asserted for two consecutive cycles, and never while in_ready=1.

Optional Feature:
- Macro: FFT_LOADER_NATURAL_ORDER_EN.
- Defined: bit reversal is bypassed. Sample k is written to buffer[k] and the frame is presented in natural order, for use with a butterfly that reorders internally.
- Not defined (default): bit-reversed write addressing exactly as described above.
- Handshake, states and timing are identical in both builds.

Test Plan:
- Reset: assert rst mid-frame after 10 accepts -> in_ready=1, fill_count=0, start=0 and all out_re/out_im=0 immediately; a full frame afterwards loads correctly.
- Full frame with in_valid held high and in_re=k, in_im=-k for k=0..63 -> start pulses exactly once, one cycle after the 64th accept. out_re[32]=1, out_re[24]=6, out_re[63]=63, out_im[32]=0xFFFF. in_ready stays 0 until fft_done.
- Gapped input, with in_valid toggling pseudo-randomly -> only handshake cycles advance fill_count. The frame content matches the bit-reversed model and start fires only after 64 accepts.
- Backpressure: in WAIT, drive in_valid=1 with changing data for 20 cycles -> in_ready=0 and the buffer is unchanged. Pulse fft_done -> in_ready=1 on the next cycle and fill_count=0.
- flush coinciding with the 64th handshake -> no start, fill_count=0, and the block stays in FILL; a subsequent 64 accepts produce one start.
- With FFT_LOADER_NATURAL_ORDER_EN defined, rerun the full-frame test -> out_re[k]=k for all k, with identical start timing.
